// File: rtl/retimer_phase_cal_if.sv
// -----------------------------------------------------------------------------
// retimer_phase_cal_if
// Bundle of control/result signals between the retimer phase calibration
// sequencer and its controller (control/JTAG register block or testbench).
//   start      : single-cycle pulse requesting a calibration sweep
//   err        : per-cycle sampling mismatch flag from the retimer checker
//   phase_sel  : phase select driven to the retimer flop bank
//   busy       : sweep in progress
//   done       : sweep finished, held until the next start
//   best_phase : phase with the fewest mismatches
//   best_err   : mismatch count measured at best_phase
// master = controller side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface retimer_phase_cal_if #(
  parameter int PHASE_W = 3,
  parameter int CNT_W   = 9
);
  logic               start;
  logic               err;
  logic [PHASE_W-1:0] phase_sel;
  logic               busy;
  logic               done;
  logic [PHASE_W-1:0] best_phase;
  logic [CNT_W-1:0]   best_err;

  modport master (
    output start, err,
    input  phase_sel, busy, done, best_phase, best_err
  );

  modport slave (
    input  start, err,
    output phase_sel, busy, done, best_phase, best_err
  );
endinterface

// File: rtl/retimer_phase_cal.sv
// -----------------------------------------------------------------------------
// retimer_phase_cal
// Calibration sequencer for the retimer flop stage. On start it steps the
// retimer phase select through every setting; at each one it waits SETTLE
// cycles, counts err over a WIN_LEN-cycle window (saturating), and keeps the
// phase with the lowest count (ties keep the lowest index). At the end it
// locks phase_sel to the winning phase and raises done.
//
// Ports:
//   clk        : block clock, posedge
//   rstb       : synchronous active-low reset
//   bus        : retimer_phase_cal_if.slave (start, err, phase_sel, busy,
//                done, best_phase, best_err)
// Optional (macro RETIMER_CAL_MANUAL_EN):
//   manual_en    : forces the sequencer idle and drives phase_sel directly
//   manual_phase : requested phase, clamped to N_PHASE-1
// -----------------------------------------------------------------------------
module retimer_phase_cal #(
  parameter int N_PHASE = 8,
  parameter int PHASE_W = 3,
  parameter int WIN_LEN = 256,
  parameter int CNT_W   = 9,
  parameter int SETTLE  = 4
) (
  input  logic                 clk,
  input  logic                 rstb,
  retimer_phase_cal_if.slave   bus
`ifdef RETIMER_CAL_MANUAL_EN
  ,
  input  logic                 manual_en,
  input  logic [PHASE_W-1:0]   manual_phase
`endif
);

  // One timer serves both the settle wait and the measurement window.
  localparam int TMR_W = $clog2(WIN_LEN + SETTLE + 1);

  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [PHASE_W-1:0] LAST_PH    = PHASE_W'(N_PHASE - 1);
  localparam logic [TMR_W-1:0]   SETTLE_END = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0]   WIN_END    = TMR_W'(WIN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_EVAL    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d, state_nxt_s;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cur_err_q, cur_err_d;
  logic [PHASE_W-1:0] phase_sel_q, phase_sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PHASE_W-1:0] best_phase_q, best_phase_d;
  logic [CNT_W-1:0]   best_err_q, best_err_d;

  logic               better_s;
  logic [PHASE_W-1:0] win_phase_s;

`ifdef RETIMER_CAL_MANUAL_EN
  function automatic logic [PHASE_W-1:0] clamp_phase(input logic [PHASE_W-1:0] ph);
    if (ph > LAST_PH) begin
      return LAST_PH;
    end else begin
      return ph;
    end
  endfunction
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) state_nxt_s = ST_SETTLE;
        else           state_nxt_s = state_q;
      end
      ST_SETTLE: begin
        if (tmr_q == SETTLE_END) state_nxt_s = ST_MEASURE;
        else                     state_nxt_s = ST_SETTLE;
      end
      ST_MEASURE: begin
        if (tmr_q == WIN_END) state_nxt_s = ST_EVAL;
        else                  state_nxt_s = ST_MEASURE;
      end
      ST_EVAL: begin
        if (phase_sel_q == LAST_PH) state_nxt_s = ST_DONE;
        else                        state_nxt_s = ST_SETTLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
`ifdef RETIMER_CAL_MANUAL_EN
    state_d = manual_en ? ST_IDLE : state_nxt_s;
`else
    state_d = state_nxt_s;
`endif
  end

  // Strict comparison so a tie keeps the earlier (lower) phase.
  always_comb begin
    better_s    = (cur_err_q < best_err_q);
    win_phase_s = better_s ? phase_sel_q : best_phase_q;
  end

  // Output/datapath next values; all outputs leave through registers.
  always_comb begin
    tmr_d        = tmr_q;
    cur_err_d    = cur_err_q;
    phase_sel_d  = phase_sel_q;
    busy_d       = busy_q;
    done_d       = done_q;
    best_phase_d = best_phase_q;
    best_err_d   = best_err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          phase_sel_d  = {PHASE_W{1'b0}};
          cur_err_d    = {CNT_W{1'b0}};
          tmr_d        = {TMR_W{1'b0}};
          best_err_d   = CNT_MAX;
          best_phase_d = {PHASE_W{1'b0}};
          done_d       = 1'b0;
          busy_d       = 1'b1;
        end else begin
          tmr_d = tmr_q;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == SETTLE_END) tmr_d = {TMR_W{1'b0}};
        else                     tmr_d = tmr_q + TMR_W'(1);
      end
      ST_MEASURE: begin
        if (bus.err && (cur_err_q != CNT_MAX)) cur_err_d = cur_err_q + CNT_W'(1);
        else                                   cur_err_d = cur_err_q;
        if (tmr_q == WIN_END) tmr_d = {TMR_W{1'b0}};
        else                  tmr_d = tmr_q + TMR_W'(1);
      end
      ST_EVAL: begin
        if (better_s) begin
          best_err_d   = cur_err_q;
          best_phase_d = phase_sel_q;
        end else begin
          best_err_d   = best_err_q;
        end
        if (phase_sel_q == LAST_PH) begin
          phase_sel_d = win_phase_s;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          phase_sel_d = phase_sel_q + PHASE_W'(1);
          cur_err_d   = {CNT_W{1'b0}};
          tmr_d       = {TMR_W{1'b0}};
        end
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
`ifdef RETIMER_CAL_MANUAL_EN
    // Manual override wins over any sweep activity but leaves results alone.
    if (manual_en) begin
      phase_sel_d  = clamp_phase(manual_phase);
      busy_d       = 1'b0;
      done_d       = 1'b0;
      best_phase_d = best_phase_q;
      best_err_d   = best_err_q;
    end else begin
      busy_d = busy_d;
    end
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      tmr_q        <= {TMR_W{1'b0}};
      cur_err_q    <= {CNT_W{1'b0}};
      phase_sel_q  <= {PHASE_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_phase_q <= {PHASE_W{1'b0}};
      best_err_q   <= {CNT_W{1'b0}};
    end else begin
      tmr_q        <= tmr_d;
      cur_err_q    <= cur_err_d;
      phase_sel_q  <= phase_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      best_phase_q <= best_phase_d;
      best_err_q   <= best_err_d;
    end
  end

  assign bus.phase_sel  = phase_sel_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.best_phase = best_phase_q;
  assign bus.best_err   = best_err_q;

endmodule

// File: tb/tb_retimer_phase_cal.sv
// -----------------------------------------------------------------------------
// tb_retimer_phase_cal
// Two sequencers: A with default parameters, B small (N_PHASE=6, WIN_LEN=20,
// CNT_W=4, SETTLE=2) so saturation and a non-power-of-two phase count are
// reached quickly. Expected results come from a cycle-offset model: the k-th
// clock edge after start belongs to phase (k-1)/P at position (k-1)%P+1 with
// P = SETTLE+WIN_LEN+1, and positions SETTLE+1..SETTLE+WIN_LEN are counted.
// -----------------------------------------------------------------------------
module tb_retimer_phase_cal;
  localparam int A_N = 8, A_W = 256, A_S = 4, A_C = 9;
  localparam int B_N = 6, B_W = 20,  B_S = 2, B_C = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb;
  logic start_v, err_v;
  int   sel;          // 0 = drive A, 1 = drive B, 2 = start goes to both
  int   n_tests = 0;
  int   n_fail  = 0;

  retimer_phase_cal_if #(.PHASE_W(3), .CNT_W(A_C)) ifa ();
  retimer_phase_cal_if #(.PHASE_W(3), .CNT_W(B_C)) ifb ();

  assign ifa.start = (sel != 1) ? start_v : 1'b0;
  assign ifb.start = (sel != 0) ? start_v : 1'b0;
  assign ifa.err   = (sel == 0) ? err_v : 1'b0;
  assign ifb.err   = (sel == 1) ? err_v : 1'b0;

`ifdef RETIMER_CAL_MANUAL_EN
  logic       man_en = 1'b0;
  logic [2:0] man_ph = 3'd0;
`endif

  retimer_phase_cal #(.N_PHASE(A_N), .PHASE_W(3), .WIN_LEN(A_W), .CNT_W(A_C), .SETTLE(A_S)) dut_a (
    .clk(clk), .rstb(rstb), .bus(ifa)
`ifdef RETIMER_CAL_MANUAL_EN
    , .manual_en(man_en), .manual_phase(man_ph)
`endif
  );

  retimer_phase_cal #(.N_PHASE(B_N), .PHASE_W(3), .WIN_LEN(B_W), .CNT_W(B_C), .SETTLE(B_S)) dut_b (
    .clk(clk), .rstb(rstb), .bus(ifb)
`ifdef RETIMER_CAL_MANUAL_EN
    , .manual_en(man_en), .manual_phase(man_ph)
`endif
  );

  // Observed outputs of the sequencer currently selected.
  logic [31:0] o_ph, o_bp, o_be, o_busy, o_done;
  always_comb begin
    if (sel == 1) begin
      o_ph = 32'(ifb.phase_sel); o_bp = 32'(ifb.best_phase); o_be = 32'(ifb.best_err);
      o_busy = 32'(ifb.busy);    o_done = 32'(ifb.done);
    end else begin
      o_ph = 32'(ifa.phase_sel); o_bp = 32'(ifa.best_phase); o_be = 32'(ifa.best_err);
      o_busy = 32'(ifa.busy);    o_done = 32'(ifa.done);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sweep. mode: 0 err only at phase 5, 1 err except at phase 3,
  // 2 err always, 3 random err. inj: start pulse inside phase 2's window.
  // abort_k: if nonzero, reset is applied at that edge and the sweep ends.
  task automatic sweep(input int d, input int mode, input bit inj, input int abort_k);
    int n, w, s, c, p, np, ph, j, cmax, bp, be;
    int cnt[8];
    logic e;
    sel = d;
    if (d == 0) begin n = A_N; w = A_W; s = A_S; c = A_C; end
    else        begin n = B_N; w = B_W; s = B_S; c = B_C; end
    p = s + w + 1;
    np = n * p;
    cmax = (1 << c) - 1;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    start_v = 1'b1;
    err_v   = 1'b0;
    @(negedge clk);
    start_v = 1'b0;
    chk("start_busy", o_busy, 32'd1);
    chk("start_done", o_done, 32'd0);
    chk("start_phase", o_ph, 32'd0);
    for (int k = 1; k <= np; k++) begin
      ph = (k - 1) / p;
      j  = (k - 1) % p + 1;
      case (mode)
        0:       e = (ph == 5);
        1:       e = (ph != 3);
        2:       e = 1'b1;
        default: e = ($urandom_range(3, 0) == 0);
      endcase
      err_v   = e;
      start_v = (inj && ph == 2 && j == s + 10);
      if (abort_k == k) rstb = 1'b0;
      if (e && j > s && j <= s + w && cnt[ph] < cmax) cnt[ph]++;
      @(negedge clk);
      if (abort_k == k) begin
        chk("abort_busy", o_busy, 32'd0);
        chk("abort_done", o_done, 32'd0);
        chk("abort_phase", o_ph, 32'd0);
        rstb  = 1'b1;
        err_v = 1'b0;
        start_v = 1'b0;
        @(negedge clk);
        chk("abort_idle", o_busy, 32'd0);
        return;
      end
      if (k % p == 0 && k < np) begin
        chk("phase_step", o_ph, 32'(k / p));
        chk("sweep_busy", o_busy, 32'd1);
      end
      if (k == np - 1) chk("done_early", o_done, 32'd0);
    end
    err_v   = 1'b0;
    start_v = 1'b0;
    be = cmax;
    bp = 0;
    for (int i = 0; i < n; i++) begin
      if (cnt[i] < be) begin be = cnt[i]; bp = i; end
    end
    chk("end_done", o_done, 32'd1);
    chk("end_busy", o_busy, 32'd0);
    chk("best_phase", o_bp, 32'(bp));
    chk("best_err", o_be, 32'(be));
    chk("final_phase", o_ph, 32'(bp));
  endtask

  initial begin
    rstb = 1'b0; start_v = 1'b1; err_v = 1'b0; sel = 2;
    repeat (3) @(negedge clk);
    chk("rst_a_busy", 32'(ifa.busy), 32'd0);
    chk("rst_a_done", 32'(ifa.done), 32'd0);
    chk("rst_a_phase", 32'(ifa.phase_sel), 32'd0);
    chk("rst_a_bp", 32'(ifa.best_phase), 32'd0);
    chk("rst_a_be", 32'(ifa.best_err), 32'd0);
    chk("rst_b_busy", 32'(ifb.busy), 32'd0);
    chk("rst_b_be", 32'(ifb.best_err), 32'd0);
    rstb = 1'b1; start_v = 1'b0;
    @(negedge clk);
    chk("post_rst_a_busy", 32'(ifa.busy), 32'd0);
    chk("post_rst_b_busy", 32'(ifb.busy), 32'd0);

    sweep(0, 0, 1'b0, 0);              // err only at phase 5
    sweep(0, 1, 1'b1, 0);              // only phase 3 clean, start ignored mid-sweep
    sweep(0, 3, 1'b0, 0);              // random
    sweep(0, 3, 1'b0, 4 * 261 + 100);  // reset during phase 4
    sweep(1, 2, 1'b0, 0);              // constant err, saturation and tie
    sweep(1, 3, 1'b0, 0);
    sweep(1, 3, 1'b0, 0);
    sweep(0, 3, 1'b0, 0);

`ifdef RETIMER_CAL_MANUAL_EN
    sel = 2;
    man_en = 1'b1; man_ph = 3'd6;
    @(negedge clk);
    chk("man_a_phase6", 32'(ifa.phase_sel), 32'd6);
    chk("man_b_clamp6", 32'(ifb.phase_sel), 32'd5);
    chk("man_a_done", 32'(ifa.done), 32'd0);
    chk("man_b_done", 32'(ifb.done), 32'd0);
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0; man_ph = 3'd7;
    chk("man_a_nostart", 32'(ifa.busy), 32'd0);
    chk("man_b_nostart", 32'(ifb.busy), 32'd0);
    @(negedge clk);
    chk("man_a_phase7", 32'(ifa.phase_sel), 32'd7);
    chk("man_b_clamp7", 32'(ifb.phase_sel), 32'd5);
    man_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("man_a_hold", 32'(ifa.phase_sel), 32'd7);
    chk("man_a_idle", 32'(ifa.busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
